rr_or_mux: RTL

Parametrised, registered N-channel multiplexer with a round-robin arbiter and a selectable OR-merge mode. It generalises the two-input OR-via-mux cell to CH channels of WIDTH bits. It adds valid/ready handshaking on every channel and a single output register stage. It sits between several producer channels and one consumer in the lab datapath.

---
 rtl/rr_or_mux.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rr_or_mux.sv
// rr_or_mux: registered CH-channel multiplexer with a round-robin arbiter
// (mode=0) and an OR-merge mode (mode=1) that consumes every valid channel
// in one beat. Each input channel has a valid/ready handshake, and there is
// a single output register stage with valid/ready toward the consumer.
//
// Optional feature macro: RR_OR_MUX_STATS_EN
//   When defined, the module has an extra output port xfer_cnt. It is a
//   16-bit saturating count of the accepted output transfers.
//   When undefined, the port and the counter do not exist.
module rr_or_mux #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHW-1:0]        out_ch
`ifdef RR_OR_MUX_STATS_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  // Channel index reached by stepping 'off' positions past pointer p, modulo CH.
  function automatic logic [CHW-1:0] rr_idx(input logic [CHW-1:0] p, input int off);
    int sum;
    sum = (int'(p) + off) % CH;
    return CHW'(sum);
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [CH-1:0] onehot(input logic [CHW-1:0] idx);
    logic [CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // The output register and the last-grant pointer.
  logic [WIDTH-1:0]           r_out_data;
  logic                       r_out_valid;
  logic [CHW-1:0]             r_out_ch;
  logic [CHW-1:0]             r_ptr;

  // Signals computed combinationally each cycle.
  logic [CH-1:0][WIDTH-1:0]   w_ch_data;
  logic                       w_load;
  logic [CHW-1:0]             w_grant;
  logic                       w_found;
  logic [CHW-1:0]             w_low;
  logic [WIDTH-1:0]           w_or_data;
  logic [WIDTH-1:0]           w_sel_data;

  // The flat input bus has the same bit layout as the packed per-channel view.
  assign w_ch_data = in_data;

  // A new beat can enter when the register is empty or is being drained in
  // this cycle. Reset blocks loading, so pending inputs stay unconsumed.
  assign w_load = (!r_out_valid || out_ready) && rst_n && (|in_valid);

  // Round-robin search: first valid channel after the last grant, wrapping modulo CH.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int off = 1; off <= CH; off++) begin
      if (!w_found && in_valid[rr_idx(r_ptr, off)]) begin
        w_found = 1'b1;
        w_grant = rr_idx(r_ptr, off);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Lowest valid channel index; it labels an OR-merged beat.
  always_comb begin
    w_low = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (in_valid[CHW'(k)]) begin
        w_low = CHW'(k);
      end else begin
        w_low = w_low;
      end
    end
  end

  // Bitwise OR of every valid channel; an invalid channel contributes zero.
  always_comb begin
    w_or_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (in_valid[CHW'(k)]) begin
        w_or_data = w_or_data | w_ch_data[CHW'(k)];
      end else begin
        w_or_data = w_or_data;
      end
    end
  end

  // Data of the granted channel in select mode.
  assign w_sel_data = w_ch_data[w_grant];

  // Handshake back to producers: grant one channel, all valid ones, or none.
  always_comb begin
    if (!w_load) begin
      in_ready = '0;
    end else if (mode) begin
      in_ready = in_valid;
    end else begin
      in_ready = onehot(w_grant);
    end
  end

  // Output register. A load captures the merged or selected beat. A drain
  // with nothing to load clears valid but keeps data and channel unchanged.
  // In every other cycle the register holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= CHW'(CH - 1);
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      if (mode) begin
        r_out_data <= w_or_data;
        r_out_ch   <= w_low;
        r_ptr      <= r_ptr;
      end else begin
        r_out_data <= w_sel_data;
        r_out_ch   <= w_grant;
        r_ptr      <= w_grant;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;

`ifdef RR_OR_MUX_STATS_EN
  logic [15:0] r_xfer_cnt;

  // Count the accepted output transfers. The count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_cnt <= 16'h0000;
    end else if (r_out_valid && out_ready && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'h0001;
    end else begin
      r_xfer_cnt <= r_xfer_cnt;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
